tlb_asid_cache: RTL and testbench
=================================

TLB_ASID_CACHE -- requirements
Module: tlb_asid_cache

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 16, number of sets (power of two, 2 to 64).
REQ-002 The block SHALL have parameter NUM_WAYS, default 4, ways per set (power of two, 1 to 8).
REQ-003 The block SHALL have parameter ASID_BITS, default 9, address-space-identifier width.
REQ-004 The block SHALL have these ports, in this order:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  translation request valid
- req_ready_o  out  1  request accepted
- vaddr_i  in  32  virtual address
- asid_i  in  ASID_BITS  requester ASID
- access_type_i  in  1  0 = read, 1 = write
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- paddr_o  out  32  physical address
- hit_o  out  1  translation found
- fault_o  out  1  access fault
- flush_valid_i  in  1  flush request
- flush_ready_o  out  1  flush accepted
- flush_mode_i  in  2  0 = all, 1 = by ASID, 2 = by ASID+VPN, 3 = reserved (treated as all)
- flush_asid_i  in  ASID_BITS  flush ASID
- flush_vpn_i  in  20  flush VPN
- ptw_req_valid_o  out  1  page-table-walk request
- ptw_req_ready_i  in  1  walker accepts
- ptw_vaddr_o  out  32  walk address
- ptw_resp_valid_i  in  1  walker response valid
- ptw_resp_ready_o  out  1  response accepted
- ptw_pte_i  in  32  PTE: [31:12] PPN, [5] G (global), [2] W, [1] R, [0] V

Function
REQ-005 Entry fields SHALL be valid, global, ASID, VPN tag, PPN and R/W permissions. Set index = VPN[log2(NUM_SETS)-1:0]; the full 20-bit VPN is stored.
REQ-006 The FSM states SHALL be IDLE, LOOKUP, PTW_REQ, PTW_WAIT, RESPOND, FLUSH.
REQ-007 req_ready_o SHALL be high only in IDLE with flush_valid_i low. flush_ready_o SHALL be high only in IDLE. A flush presented in the same cycle as a request takes priority.
REQ-008 On request accept, vaddr, ASID and access type SHALL be registered and the FSM SHALL enter LOOKUP.
REQ-009 In LOOKUP, a way hits when valid && VPN matches && (global || ASID matches). At most one way hits; if several match, the lowest index wins.
REQ-010 Permission checks:
- Hit with permission OK: paddr = {PPN, offset}, hit = 1, fault = 0; go to RESPOND.
- Hit with permission missing: paddr = 0, hit = 1, fault = 1; go to RESPOND.
- Miss: go to PTW_REQ.
- Hit latency: resp_valid_o rises 2 cycles after the accept edge.
REQ-011 PTW_REQ SHALL hold ptw_req_valid_o high with ptw_vaddr_o = the registered vaddr until ptw_req_ready_i is seen. ptw_resp_ready_o SHALL be high only in PTW_WAIT.
REQ-012 On PTE receipt:
- V = 0: hit = 0, fault = 1, no fill.
- V = 1 with missing permission: hit = 1, fault = 1, no fill.
- Otherwise: fill the victim way, hit = 1, fault = 0, paddr = {PPN, offset}.
- In all three cases the FSM goes to RESPOND.
REQ-013 Victim selection: the lowest-index invalid way; otherwise the way with the maximum age, lowest index on a tie.
REQ-014 Ages SHALL be clog2(NUM_WAYS) bits per entry. On a hit-OK or fill, the touched way's age becomes 0 and every way in the set whose age is below the old age increments. A faulting hit does not update ages.
REQ-015 RESPOND SHALL hold resp_valid_o and the outputs stable until resp_ready_i is seen, then return to IDLE. hit_o and fault_o SHALL clear on that handshake; paddr_o keeps its value.
REQ-016 FLUSH SHALL visit one set per cycle, from set 0 to NUM_SETS-1, and invalidate the matching entries:
- Mode 0: all entries.
- Mode 1: non-global entries with a matching ASID.
- Mode 2: non-global entries with matching ASID and VPN.
- Then return to IDLE, so a flush occupies exactly NUM_SETS cycles.
REQ-017 A fill SHALL never occur during FLUSH. Requests are blocked until the flush completes.

Reset
REQ-018 While rst is high:
- The FSM returns to IDLE from any state, including mid-walk and mid-flush.
- All valid bits clear and all ages reset to the way index.
- All outputs go to 0, except req_ready_o and flush_ready_o, which follow REQ-007 in IDLE.
- An outstanding walker response arriving after reset is ignored.

Structure
REQ-019 The shared package tlb_pkg SHALL hold the state encoding, the PTE bit positions and the flush-mode constants.
REQ-020 Storage with read/write/age ports SHALL be the single sub-module tlb_asid_storage. Lookup, victim selection and the FSM live in the top level.

Verification
REQ-021 Verification SHALL cover these directed scenarios:
- Cold read of 0x0001_2345, ASID 3; walker returns 0x000A_B007 -> PTW issued with vaddr 0x0001_2345, response paddr 0x000A_B345, hit = 1, fault = 0. A repeat request hits with no PTW, response 2 cycles after accept.
- Same VPN, ASID 4, non-global entry -> miss and PTW. With a PTE having G = 1 (0x000A_B027), a later access under ASID 4 hits.
- Write to a page filled from PTE 0x0000_5003 -> hit = 1, fault = 1, paddr = 0. Walker PTE 0x0 -> hit = 0, fault = 1, no fill.
- Fill NUM_WAYS+1 VPNs mapping to set 0, touching way 0 between fills -> the evicted way is the oldest, not way 0.
- Flush mode 1 with ASID 3 -> ASID-3 non-global entries miss, global and ASID-5 entries still hit. flush_ready_o low for 16 cycles at default parameters.
- rst asserted in PTW_WAIT, then a walker response -> no fill, outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the ASID-tagged TLB: controller states, PTE field
// positions, flush-mode codes and an index-width helper.
package tlb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    PTW_REQ,
    PTW_WAIT,
    RESPOND,
    FLUSH
  } state_t;

  localparam int PAGE_BITS = 12;
  localparam int VPN_BITS  = 20;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_G       = 5;
  localparam int PTE_PPN_LSB = 12;

  localparam logic [1:0] FLUSH_ALL      = 2'd0;
  localparam logic [1:0] FLUSH_ASID     = 2'd1;
  localparam logic [1:0] FLUSH_ASID_VPN = 2'd2;

  // Way index / age width; a direct-mapped TLB still needs a 1-bit field.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_asid_storage.sv
// Set-associative entry store: registered read of one whole set, single-way
// fill, age (LRU-rank) update and per-set flush invalidation.
module tlb_asid_storage
  import tlb_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 4,
  parameter int ASID_BITS = 9,
  parameter int SET_BITS  = $clog2(NUM_SETS),
  parameter int WAY_BITS  = idx_bits(NUM_WAYS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SET_BITS-1:0]                 set_idx,
  output logic [NUM_WAYS-1:0]                 rd_valid,
  output logic [NUM_WAYS-1:0]                 rd_global,
  output logic [NUM_WAYS-1:0]                 rd_r,
  output logic [NUM_WAYS-1:0]                 rd_w,
  output logic [NUM_WAYS-1:0][ASID_BITS-1:0]  rd_asid,
  output logic [NUM_WAYS-1:0][VPN_BITS-1:0]   rd_vpn,
  output logic [NUM_WAYS-1:0][VPN_BITS-1:0]   rd_ppn,
  output logic [NUM_WAYS-1:0][WAY_BITS-1:0]   rd_age,
  input  logic                                wr_en,
  input  logic [WAY_BITS-1:0]                 wr_way,
  input  logic                                wr_global,
  input  logic [ASID_BITS-1:0]                wr_asid,
  input  logic [VPN_BITS-1:0]                 wr_vpn,
  input  logic [VPN_BITS-1:0]                 wr_ppn,
  input  logic                                wr_r,
  input  logic                                wr_w,
  input  logic                                touch_en,
  input  logic [WAY_BITS-1:0]                 touch_way,
  input  logic                                flush_en,
  input  logic [SET_BITS-1:0]                 flush_set,
  input  logic [1:0]                          flush_mode,
  input  logic [ASID_BITS-1:0]                flush_asid,
  input  logic [VPN_BITS-1:0]                 flush_vpn
);

  logic [NUM_WAYS-1:0]                valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0]                global_q [NUM_SETS];
  logic [NUM_WAYS-1:0]                r_q      [NUM_SETS];
  logic [NUM_WAYS-1:0]                w_q      [NUM_SETS];
  logic [NUM_WAYS-1:0][ASID_BITS-1:0] asid_q   [NUM_SETS];
  logic [NUM_WAYS-1:0][VPN_BITS-1:0]  vpn_q    [NUM_SETS];
  logic [NUM_WAYS-1:0][VPN_BITS-1:0]  ppn_q    [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_BITS-1:0]  age_q    [NUM_SETS];

  logic [NUM_WAYS-1:0]               kill;
  logic [NUM_WAYS-1:0][WAY_BITS-1:0] next_age;
  logic [WAY_BITS-1:0]               old_age;

  // NOTE: every variable of an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    kill = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      case (flush_mode)
        FLUSH_ASID:
          kill[w] = !global_q[flush_set][w] && (asid_q[flush_set][w] == flush_asid);
        FLUSH_ASID_VPN:
          kill[w] = !global_q[flush_set][w] && (asid_q[flush_set][w] == flush_asid)
                    && (vpn_q[flush_set][w] == flush_vpn);
        default: kill[w] = 1'b1;
      endcase
    end
  end

  // Touched way becomes youngest; only ways younger than it age, so ranks stay a permutation.
  always_comb begin
    old_age  = age_q[set_idx][touch_way];
    next_age = age_q[set_idx];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_BITS'(w) == touch_way) next_age[w] = '0;
      else if (age_q[set_idx][w] < old_age) next_age[w] = age_q[set_idx][w] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_BITS'(w);
      end
    end else begin
      if (flush_en) valid_q[flush_set] <= valid_q[flush_set] & ~kill;
      else if (wr_en) valid_q[set_idx][wr_way] <= 1'b1;
      if (touch_en) age_q[set_idx] <= next_age;
    end
  end

  // NOTE: entry payload and read registers carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      global_q[set_idx][wr_way] <= wr_global;
      r_q[set_idx][wr_way]      <= wr_r;
      w_q[set_idx][wr_way]      <= wr_w;
      asid_q[set_idx][wr_way]   <= wr_asid;
      vpn_q[set_idx][wr_way]    <= wr_vpn;
      ppn_q[set_idx][wr_way]    <= wr_ppn;
    end
    rd_valid  <= valid_q[set_idx];
    rd_global <= global_q[set_idx];
    rd_r      <= r_q[set_idx];
    rd_w      <= w_q[set_idx];
    rd_asid   <= asid_q[set_idx];
    rd_vpn    <= vpn_q[set_idx];
    rd_ppn    <= ppn_q[set_idx];
    rd_age    <= age_q[set_idx];
  end

endmodule

// File: rtl/tlb_asid_cache.sv
// ASID-tagged set-associative TLB: lookup, permission check, page-table-walk
// refill with age-based replacement, and set-by-set flush.
module tlb_asid_cache
  import tlb_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 4,
  parameter int ASID_BITS = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          vaddr_i,
  input  logic [ASID_BITS-1:0] asid_i,
  input  logic                 access_type_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [31:0]          paddr_o,
  output logic                 hit_o,
  output logic                 fault_o,
  input  logic                 flush_valid_i,
  output logic                 flush_ready_o,
  input  logic [1:0]           flush_mode_i,
  input  logic [ASID_BITS-1:0] flush_asid_i,
  input  logic [19:0]          flush_vpn_i,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output logic [31:0]          ptw_vaddr_o,
  input  logic                 ptw_resp_valid_i,
  output logic                 ptw_resp_ready_o,
  input  logic [31:0]          ptw_pte_i
);

  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = idx_bits(NUM_WAYS);

  state_t state_q, state_d;
  logic [31:0]          vaddr_q, paddr_q, paddr_d;
  logic [ASID_BITS-1:0] asid_q, fasid_q;
  logic [VPN_BITS-1:0]  fvpn_q;
  logic [1:0]           fmode_q;
  logic [SET_BITS-1:0]  fset_q;
  logic access_q, rd_ready_q, hit_q, fault_q;
  logic resp_load, hit_d, fault_d, wr_en, touch_en, flush_en;
  logic hit_any, inv_found;
  logic [WAY_BITS-1:0] hit_way, inv_way, old_way, victim_way, touch_way;
  logic [VPN_BITS-1:0] vpn_q;

  logic [NUM_WAYS-1:0]                rd_valid, rd_global, rd_r, rd_w;
  logic [NUM_WAYS-1:0][ASID_BITS-1:0] rd_asid;
  logic [NUM_WAYS-1:0][VPN_BITS-1:0]  rd_vpn, rd_ppn;
  logic [NUM_WAYS-1:0][WAY_BITS-1:0]  rd_age;

  logic pte_v, pte_perm, hit_perm, unused_pte;

  assign vpn_q      = vaddr_q[31:PAGE_BITS];
  assign pte_v      = ptw_pte_i[PTE_V];
  assign pte_perm   = access_q ? ptw_pte_i[PTE_W] : ptw_pte_i[PTE_R];
  assign hit_perm   = access_q ? rd_w[hit_way] : rd_r[hit_way];
  assign unused_pte = ^{ptw_pte_i[11:6], ptw_pte_i[4:3]};

  assign req_ready_o      = (state_q == IDLE) && !flush_valid_i;
  assign flush_ready_o    = (state_q == IDLE);
  assign resp_valid_o     = (state_q == RESPOND);
  assign ptw_req_valid_o  = (state_q == PTW_REQ);
  assign ptw_resp_ready_o = (state_q == PTW_WAIT);
  assign ptw_vaddr_o      = vaddr_q;
  assign paddr_o          = paddr_q;
  assign hit_o            = hit_q;
  assign fault_o          = fault_q;

  tlb_asid_storage #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .ASID_BITS(ASID_BITS)
  ) u_storage (
    .clk       (clk),
    .rst       (rst),
    .set_idx   (vaddr_q[PAGE_BITS +: SET_BITS]),
    .rd_valid  (rd_valid),
    .rd_global (rd_global),
    .rd_r      (rd_r),
    .rd_w      (rd_w),
    .rd_asid   (rd_asid),
    .rd_vpn    (rd_vpn),
    .rd_ppn    (rd_ppn),
    .rd_age    (rd_age),
    .wr_en     (wr_en),
    .wr_way    (victim_way),
    .wr_global (ptw_pte_i[PTE_G]),
    .wr_asid   (asid_q),
    .wr_vpn    (vpn_q),
    .wr_ppn    (ptw_pte_i[31:PTE_PPN_LSB]),
    .wr_r      (ptw_pte_i[PTE_R]),
    .wr_w      (ptw_pte_i[PTE_W]),
    .touch_en  (touch_en),
    .touch_way (touch_way),
    .flush_en  (flush_en),
    .flush_set (fset_q),
    .flush_mode(fmode_q),
    .flush_asid(fasid_q),
    .flush_vpn (fvpn_q)
  );

  // Tag match (lowest way wins) and victim choice: first invalid way, else oldest.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_vpn[w] == vpn_q) && (rd_global[w] || (rd_asid[w] == asid_q))) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!rd_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (rd_age[w] > rd_age[old_way]) old_way = WAY_BITS'(w);
    end
    victim_way = inv_found ? inv_way : old_way;
  end

  always_comb begin
    state_d   = state_q;
    resp_load = 1'b0;
    hit_d     = 1'b0;
    fault_d   = 1'b0;
    paddr_d   = '0;
    wr_en     = 1'b0;
    touch_en  = 1'b0;
    touch_way = victim_way;
    flush_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_valid_i) state_d = FLUSH;
        else if (req_valid_i) state_d = LOOKUP;
      end
      // First LOOKUP cycle only waits for the registered set read.
      LOOKUP: begin
        if (rd_ready_q) begin
          if (hit_any) begin
            state_d   = RESPOND;
            resp_load = 1'b1;
            hit_d     = 1'b1;
            fault_d   = !hit_perm;
            if (hit_perm) begin
              paddr_d   = {rd_ppn[hit_way], vaddr_q[PAGE_BITS-1:0]};
              touch_en  = 1'b1;
              touch_way = hit_way;
            end
          end else begin
            state_d = PTW_REQ;
          end
        end
      end
      PTW_REQ: if (ptw_req_ready_i) state_d = PTW_WAIT;
      PTW_WAIT: begin
        if (ptw_resp_valid_i) begin
          state_d   = RESPOND;
          resp_load = 1'b1;
          hit_d     = pte_v;
          fault_d   = !(pte_v && pte_perm);
          if (pte_v && pte_perm) begin
            paddr_d  = {ptw_pte_i[31:PTE_PPN_LSB], vaddr_q[PAGE_BITS-1:0]};
            wr_en    = 1'b1;
            touch_en = 1'b1;
          end
        end
      end
      RESPOND: if (resp_ready_i) state_d = IDLE;
      FLUSH: begin
        flush_en = 1'b1;
        if (fset_q == SET_BITS'(NUM_SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vaddr_q    <= '0;
      asid_q     <= '0;
      access_q   <= 1'b0;
      rd_ready_q <= 1'b0;
      fmode_q    <= FLUSH_ALL;
      fasid_q    <= '0;
      fvpn_q     <= '0;
      fset_q     <= '0;
      paddr_q    <= '0;
      hit_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ready_q <= (state_q == LOOKUP) && !rd_ready_q;
      if (req_valid_i && req_ready_o) begin
        vaddr_q  <= vaddr_i;
        asid_q   <= asid_i;
        access_q <= access_type_i;
      end
      if (flush_valid_i && flush_ready_o) begin
        fmode_q <= flush_mode_i;
        fasid_q <= flush_asid_i;
        fvpn_q  <= flush_vpn_i;
        fset_q  <= '0;
      end else if (state_q == FLUSH) begin
        fset_q <= fset_q + 1'b1;
      end
      if (resp_load) begin
        paddr_q <= paddr_d;
        hit_q   <= hit_d;
        fault_q <= fault_d;
      end else if ((state_q == RESPOND) && resp_ready_i) begin
        hit_q   <= 1'b0;
        fault_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tlb_asid_cache.sv
// Directed self-checking bench for tlb_asid_cache at default parameters.
module tb_tlb_asid_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [31:0] vaddr_i;
  logic [8:0]  asid_i;
  logic        access_type_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] paddr_o;
  logic        hit_o, fault_o;
  logic        flush_valid_i, flush_ready_o;
  logic [1:0]  flush_mode_i;
  logic [8:0]  flush_asid_i;
  logic [19:0] flush_vpn_i;
  logic        ptw_req_valid_o, ptw_req_ready_i;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i, ptw_resp_ready_o;
  logic [31:0] ptw_pte_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic        got_ptw, r_hit, r_fault, p_hit, p_fault;
  logic [31:0] ptw_addr, r_paddr, p_paddr;
  int          lat;

  always #5 clk = ~clk;

  tlb_asid_cache dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .vaddr_i(vaddr_i), .asid_i(asid_i), .access_type_i(access_type_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .paddr_o(paddr_o), .hit_o(hit_o), .fault_o(fault_o),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .flush_mode_i(flush_mode_i), .flush_asid_i(flush_asid_i), .flush_vpn_i(flush_vpn_i),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_vaddr_o(ptw_vaddr_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ready_o(ptw_resp_ready_o),
    .ptw_pte_i(ptw_pte_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One translation; the walker (if asked) accepts at once and answers with pte.
  task automatic run_req(input logic [31:0] va, input logic [8:0] as, input logic wr,
                         input logic [31:0] pte);
    got_ptw  = 1'b0;
    ptw_addr = '0;
    lat      = 0;
    vaddr_i = va; asid_i = as; access_type_i = wr; req_valid_i = 1'b1;
    ptw_pte_i = pte; ptw_req_ready_i = 1'b1; ptw_resp_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ptw_req_valid_o) begin
        got_ptw  = 1'b1;
        ptw_addr = ptw_vaddr_o;
      end
      if (resp_valid_o) begin
        lat = n;
        break;
      end
    end
    ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0;
    if (!resp_valid_o) begin
      check("resp_timeout", {31'd0, resp_valid_o}, 32'd1);
    end else begin
      r_paddr = paddr_o; r_hit = hit_o; r_fault = fault_o;
      resp_ready_i = 1'b1;
      @(posedge clk); #1;
      resp_ready_i = 1'b0;
      p_paddr = paddr_o; p_hit = hit_o; p_fault = fault_o;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    rst = 1'b1;
    req_valid_i = 0; vaddr_i = 0; asid_i = 0; access_type_i = 0; resp_ready_i = 0;
    flush_valid_i = 0; flush_mode_i = 0; flush_asid_i = 0; flush_vpn_i = 0;
    ptw_req_ready_i = 0; ptw_resp_valid_i = 0; ptw_pte_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_ptw_req", {31'd0, ptw_req_valid_o}, 32'd0);
    check("rst_hit_fault", {30'd0, hit_o, fault_o}, 32'd0);
    check("rst_paddr", paddr_o, 32'd0);
    check("rst_readies", {30'd0, req_ready_o, flush_ready_o}, 32'd3);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold read, then a repeat that must hit without a walk.
    run_req(32'h0001_2345, 9'd3, 1'b0, 32'h000A_B007);
    check("cold_ptw", {31'd0, got_ptw}, 32'd1);
    check("cold_ptw_vaddr", ptw_addr, 32'h0001_2345);
    check("cold_paddr", r_paddr, 32'h000A_B345);
    check("cold_hit_fault", {30'd0, r_hit, r_fault}, 32'd2);
    check("post_hs_hit_fault", {30'd0, p_hit, p_fault}, 32'd0);
    check("post_hs_paddr", p_paddr, 32'h000A_B345);
    run_req(32'h0001_2345, 9'd3, 1'b0, 32'h0);
    check("warm_no_ptw", {31'd0, got_ptw}, 32'd0);
    check("warm_latency", lat, 32'd2);
    check("warm_paddr", r_paddr, 32'h000A_B345);

    // Other ASID misses the non-global entry; a global fill then serves any ASID.
    run_req(32'h0001_2345, 9'd4, 1'b0, 32'h000A_B027);
    check("asid4_ptw", {31'd0, got_ptw}, 32'd1);
    check("asid4_paddr", r_paddr, 32'h000A_B345);
    run_req(32'h0001_2FFF, 9'd4, 1'b0, 32'h0);
    check("asid4_hit_no_ptw", {31'd0, got_ptw}, 32'd0);
    check("asid4_hit_paddr", r_paddr, 32'h000A_BFFF);
    run_req(32'h0001_2000, 9'd7, 1'b0, 32'h0);
    check("global_other_asid", {30'd0, got_ptw, r_hit}, 32'd1);

    // Permission fault on a hit, invalid PTE fault without fill.
    run_req(32'h0003_3010, 9'd3, 1'b0, 32'h0000_5003);
    check("ro_fill_paddr", r_paddr, 32'h0000_5010);
    run_req(32'h0003_3010, 9'd3, 1'b1, 32'h0);
    check("wr_fault_no_ptw", {31'd0, got_ptw}, 32'd0);
    check("wr_fault_flags", {30'd0, r_hit, r_fault}, 32'd3);
    check("wr_fault_paddr", r_paddr, 32'd0);
    run_req(32'h0004_4ABC, 9'd3, 1'b0, 32'h0);
    check("pte_inv_flags", {29'd0, got_ptw, r_hit, r_fault}, 32'd5);
    run_req(32'h0004_4ABC, 9'd3, 1'b0, 32'h000C_C003);
    check("pte_inv_nofill", {31'd0, got_ptw}, 32'd1);
    check("pte_refill_paddr", r_paddr, 32'h000C_CABC);

    // Set 0: fill A,B,C,D touching A between fills; E must evict B.
    run_req(32'h0010_0000, 9'd3, 1'b0, 32'h00A0_1007);
    run_req(32'h0011_0000, 9'd3, 1'b0, 32'h00B0_1007);
    run_req(32'h0010_0000, 9'd3, 1'b0, 32'h0);
    run_req(32'h0012_0000, 9'd3, 1'b0, 32'h00C0_1007);
    run_req(32'h0010_0000, 9'd3, 1'b0, 32'h0);
    run_req(32'h0013_0000, 9'd3, 1'b0, 32'h00D0_1007);
    run_req(32'h0010_0000, 9'd3, 1'b0, 32'h0);
    check("touch_a_hit", {31'd0, got_ptw}, 32'd0);
    run_req(32'h0014_0000, 9'd3, 1'b0, 32'h00E0_1007);
    check("fill_e_paddr", r_paddr, 32'h00E0_1000);
    run_req(32'h0012_0000, 9'd3, 1'b0, 32'h0);
    check("evict_c_kept", {31'd0, got_ptw}, 32'd0);
    run_req(32'h0013_0000, 9'd3, 1'b0, 32'h0);
    check("evict_d_kept", {31'd0, got_ptw}, 32'd0);
    run_req(32'h0010_0000, 9'd3, 1'b0, 32'h0);
    check("evict_a_kept", {31'd0, got_ptw}, 32'd0);
    check("evict_a_paddr", r_paddr, 32'h00A0_1000);
    run_req(32'h0011_0000, 9'd3, 1'b0, 32'h00B0_1007);
    check("evict_b_gone", {31'd0, got_ptw}, 32'd1);

    // Flush by ASID 3, presented together with a request (flush wins).
    run_req(32'h0005_5000, 9'd5, 1'b0, 32'h0007_7007);
    flush_valid_i = 1'b1; flush_mode_i = 2'd1; flush_asid_i = 9'd3;
    req_valid_i = 1'b1; vaddr_i = 32'h0003_3010; asid_i = 9'd3;
    #1;
    check("flush_prio_ready", {30'd0, flush_ready_o, req_ready_o}, 32'd2);
    @(posedge clk); #1;
    flush_valid_i = 1'b0; req_valid_i = 1'b0;
    busy = 0;
    for (int n = 0; n < 40; n++) begin
      if (flush_ready_o) break;
      busy++;
      @(posedge clk); #1;
    end
    check("flush_busy_cycles", busy, 32'd16);
    check("flush_no_req", {31'd0, resp_valid_o}, 32'd0);
    run_req(32'h0003_3010, 9'd3, 1'b0, 32'h0000_5003);
    check("flush_asid3_miss", {31'd0, got_ptw}, 32'd1);
    run_req(32'h0014_0000, 9'd3, 1'b0, 32'h00E0_1007);
    check("flush_asid3_miss2", {31'd0, got_ptw}, 32'd1);
    run_req(32'h0001_2345, 9'd3, 1'b0, 32'h0);
    check("flush_global_kept", {30'd0, got_ptw, r_hit}, 32'd1);
    run_req(32'h0005_5000, 9'd5, 1'b0, 32'h0);
    check("flush_asid5_kept", {31'd0, got_ptw}, 32'd0);
    check("flush_asid5_paddr", r_paddr, 32'h0007_7000);

    // Reset while waiting on the walker; the late response must be ignored.
    vaddr_i = 32'h0006_6000; asid_i = 9'd3; access_type_i = 1'b0; req_valid_i = 1'b1;
    ptw_req_ready_i = 1'b1; ptw_resp_valid_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (ptw_resp_ready_o) break;
      @(posedge clk); #1;
    end
    check("reach_ptw_wait", {31'd0, ptw_resp_ready_o}, 32'd1);
    ptw_req_ready_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwalk_rst_outs", {27'd0, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o, hit_o, fault_o}, 32'd0);
    rst = 1'b0;
    ptw_resp_valid_i = 1'b1; ptw_pte_i = 32'h0009_9007;
    repeat (3) @(posedge clk);
    #1;
    ptw_resp_valid_i = 1'b0;
    check("late_pte_ignored", {28'd0, resp_valid_o, ptw_resp_ready_o, hit_o, fault_o}, 32'd0);
    check("late_pte_paddr", paddr_o, 32'd0);
    check("late_pte_idle", {30'd0, req_ready_o, flush_ready_o}, 32'd3);
    run_req(32'h0006_6000, 9'd3, 1'b0, 32'h0009_9007);
    check("late_pte_no_fill", {31'd0, got_ptw}, 32'd1);
    run_req(32'h0001_2345, 9'd3, 1'b0, 32'h000A_B007);
    check("rst_cleared_valid", {31'd0, got_ptw}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
